// File: rtl/soc_region_seq.sv
`default_nettype none
// ============================================================================
// Module      : soc_region_seq
// Description : Multi-channel ring-oscillator edge counter. Counts rising
//               edges of NUM_CH asynchronous oscillator taps over a
//               programmable window of clk cycles. It supports single-shot
//               and continuous framing, per-channel enables and saturating
//               counters with an overflow flag. Results go to an internal
//               NUM_CH-entry result bank that is read by address.
// Revision    : 1.0 - initial release
// ----------------------------------------------------------------------------
// Ports
//   clk        in   1       system clock (single domain)
//   rst        in   1       synchronous reset, active-high
//   osc_i      in   NUM_CH  asynchronous oscillator taps
//   ch_en_i    in   NUM_CH  per-channel enable, latched at start
//   start_i    in   1       start request, honoured only in IDLE
//   mode_i     in   1       0 = single-shot, 1 = continuous (latched at start)
//   stop_i     in   1       continuous mode: finish this frame, then go IDLE
//   win_len_i  in   WIN_W   window length in clk cycles (0 acts as 1)
//   rd_addr_i  in   ADDR_W  result bank read address
//   rd_data_o  out  CNT_W   registered result data
//   rd_ovf_o   out  1       registered overflow flag of the addressed entry
//   busy_o     out  1       high in SETTLE, COUNT and STORE
//   done_o     out  1       one-cycle pulse per completed frame
//   frame_o    out  16      completed-frame count (wraps)
// ============================================================================
module soc_region_seq #(
  parameter int NUM_CH = 5,
  parameter int CNT_W  = 24,
  parameter int WIN_W  = 20,
  parameter int ADDR_W = 5
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [NUM_CH-1:0] osc_i,
  input  logic [NUM_CH-1:0] ch_en_i,
  input  logic              start_i,
  input  logic              mode_i,
  input  logic              stop_i,
  input  logic [WIN_W-1:0]  win_len_i,
  input  logic [ADDR_W-1:0] rd_addr_i,
  output logic [CNT_W-1:0]  rd_data_o,
  output logic              rd_ovf_o,
  output logic              busy_o,
  output logic              done_o,
  output logic [15:0]       frame_o
);

  localparam int                 c_IDX_W    = (NUM_CH > 1) ? $clog2(NUM_CH) : 1;
  localparam logic [CNT_W-1:0]   c_CNT_MAX  = {CNT_W{1'b1}};
  localparam logic [c_IDX_W-1:0] c_LAST_IDX = c_IDX_W'(NUM_CH - 1);
  localparam logic [ADDR_W:0]    c_NUM_CH_A = (ADDR_W + 1)'(NUM_CH);

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_SETTLE = 3'd1,
    S_COUNT  = 3'd2,
    S_STORE  = 3'd3,
    S_DONE   = 3'd4
  } state_t;

  state_t              r_state;

  // Oscillator input path
  logic [NUM_CH-1:0]   r_sync1;
  logic [NUM_CH-1:0]   r_sync2;
  logic [NUM_CH-1:0]   r_sync3;
  logic [NUM_CH-1:0]   r_edge;

  // Frame configuration captured at start
  logic [NUM_CH-1:0]   r_enLat;
  logic                r_modeLat;
  logic [WIN_W-1:0]    r_winLat;
  logic                r_stopSeen;

  // Sequencing
  logic [1:0]          r_settleCnt;
  logic [WIN_W-1:0]    r_winTimer;
  logic [c_IDX_W-1:0]  r_storeIdx;

  // Edge counters and result bank
  logic [CNT_W-1:0]    r_cnt [NUM_CH];
  logic [NUM_CH-1:0]   r_cntOvf;
  logic [CNT_W-1:0]    r_bankData [NUM_CH];
  logic [NUM_CH-1:0]   r_bankOvf;

  logic [c_IDX_W-1:0]  w_rdIdx;
  logic                w_rdHit;
  logic                w_busyState;

  assign w_busyState = (r_state == S_SETTLE) || (r_state == S_COUNT) || (r_state == S_STORE);

  // --------------------------------------------------------------------------
  // Two-flop synchroniser followed by a registered rising-edge detector. The
  // third flop only holds the previous synchronised level for the compare.
  // --------------------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (rst) begin
      r_sync1 <= '0;
      r_sync2 <= '0;
      r_sync3 <= '0;
      r_edge  <= '0;
    end else begin
      r_sync1 <= osc_i;
      r_sync2 <= r_sync1;
      r_sync3 <= r_sync2;
      r_edge  <= r_sync2 & ~r_sync3;
    end
  end

  // --------------------------------------------------------------------------
  // Edge counters. They are held at zero outside COUNT/STORE, which also
  // clears them on the DONE cycle ready for the next continuous frame. At
  // saturation the count freezes and any further edge sets the overflow flag.
  // --------------------------------------------------------------------------
  always_ff @(posedge clk) begin
    for (int i = 0; i < NUM_CH; i++) begin
      if (rst || !((r_state == S_COUNT) || (r_state == S_STORE))) begin
        r_cnt[i]    <= '0;
        r_cntOvf[i] <= 1'b0;
      end else if ((r_state == S_COUNT) && r_edge[i] && r_enLat[i]) begin
        if (r_cnt[i] == c_CNT_MAX) begin
          r_cntOvf[i] <= 1'b1;
        end else begin
          r_cnt[i] <= r_cnt[i] + 1'b1;
        end
      end
    end
  end

  // --------------------------------------------------------------------------
  // Frame sequencer. busy_o/done_o/frame_o are registered and updated on the
  // same edge as the state transition that defines them.
  // --------------------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state     <= S_IDLE;
      r_enLat     <= '0;
      r_modeLat   <= 1'b0;
      r_winLat    <= '0;
      r_stopSeen  <= 1'b0;
      r_settleCnt <= '0;
      r_winTimer  <= '0;
      r_storeIdx  <= '0;
      r_bankOvf   <= '0;
      busy_o      <= 1'b0;
      done_o      <= 1'b0;
      frame_o     <= '0;
      for (int i = 0; i < NUM_CH; i++) begin
        r_bankData[i] <= '0;
      end
    end else begin
      done_o <= 1'b0;

      if (w_busyState && stop_i) begin
        r_stopSeen <= 1'b1;
      end

      case (r_state)
        S_IDLE: begin
          r_stopSeen <= 1'b0;
          if (start_i) begin
            r_enLat     <= ch_en_i;
            r_modeLat   <= mode_i;
            r_winLat    <= (win_len_i == '0) ? WIN_W'(1) : win_len_i;
            r_settleCnt <= 2'd2;
            busy_o      <= 1'b1;
            r_state     <= S_SETTLE;
          end
        end

        // Three cycles for the synchronisers to flush stale levels.
        S_SETTLE: begin
          if (r_settleCnt == 2'd0) begin
            r_winTimer <= r_winLat - 1'b1;
            r_state    <= S_COUNT;
          end else begin
            r_settleCnt <= r_settleCnt - 1'b1;
          end
        end

        S_COUNT: begin
          if (r_winTimer == '0) begin
            r_storeIdx <= '0;
            r_state    <= S_STORE;
          end else begin
            r_winTimer <= r_winTimer - 1'b1;
          end
        end

        // One bank entry per cycle; disabled channels store 0/0.
        S_STORE: begin
          r_bankData[r_storeIdx] <= r_enLat[r_storeIdx] ? r_cnt[r_storeIdx] : '0;
          r_bankOvf[r_storeIdx]  <= r_enLat[r_storeIdx] & r_cntOvf[r_storeIdx];
          if (r_storeIdx == c_LAST_IDX) begin
            busy_o  <= 1'b0;
            done_o  <= 1'b1;
            frame_o <= frame_o + 16'd1;
            r_state <= S_DONE;
          end else begin
            r_storeIdx <= r_storeIdx + 1'b1;
          end
        end

        S_DONE: begin
          if (r_modeLat && !r_stopSeen) begin
            r_settleCnt <= 2'd2;
            busy_o      <= 1'b1;
            r_state     <= S_SETTLE;
          end else begin
            r_stopSeen <= 1'b0;
            r_state    <= S_IDLE;
          end
        end

        default: begin
          busy_o  <= 1'b0;
          r_state <= S_IDLE;
        end
      endcase
    end
  end

  // --------------------------------------------------------------------------
  // Read port. Out-of-range addresses return 0/0. A read that coincides with a
  // STORE write to the same entry sees the pre-write contents.
  // --------------------------------------------------------------------------
  assign w_rdIdx = rd_addr_i[c_IDX_W-1:0];
  assign w_rdHit = ({1'b0, rd_addr_i} < c_NUM_CH_A);

  always_ff @(posedge clk) begin
    if (rst) begin
      rd_data_o <= '0;
      rd_ovf_o  <= 1'b0;
    end else if (w_rdHit) begin
      rd_data_o <= r_bankData[w_rdIdx];
      rd_ovf_o  <= r_bankOvf[w_rdIdx];
    end else begin
      rd_data_o <= '0;
      rd_ovf_o  <= 1'b0;
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_soc_region_seq.sv
`default_nettype none
// ============================================================================
// Module      : tb_soc_region_seq
// Description : Scoreboard bench for soc_region_seq. The oscillator driver
//               toggles taps only well inside each counting window and tallies
//               the rising edges it produces. Expected bank contents are
//               derived from those tallies: min(rises, max) for an enabled
//               channel, with ovf set once rises exceed the maximum. Frame
//               completion is predicted from the frame timing:
//               done 3+W+NUM_CH edges after the frame's start edge, and
//               back-to-back frames 4+W+NUM_CH edges apart.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_soc_region_seq;

  localparam int NUM_CH  = 5;
  localparam int CNT_W   = 6;
  localparam int WIN_W   = 12;
  localparam int ADDR_W  = 5;
  localparam int CNT_MAX = (1 << CNT_W) - 1;
  localparam int MAX_FR  = 8;

  logic              clk       = 1'b0;
  logic              rst       = 1'b1;
  logic [NUM_CH-1:0] osc_i     = '0;
  logic [NUM_CH-1:0] ch_en_i   = '0;
  logic              start_i   = 1'b0;
  logic              mode_i    = 1'b0;
  logic              stop_i    = 1'b0;
  logic [WIN_W-1:0]  win_len_i = '0;
  logic [ADDR_W-1:0] rd_addr_i = '0;
  logic [CNT_W-1:0]  rd_data_o;
  logic              rd_ovf_o;
  logic              busy_o;
  logic              done_o;
  logic [15:0]       frame_o;

  soc_region_seq #(
    .NUM_CH (NUM_CH),
    .CNT_W  (CNT_W),
    .WIN_W  (WIN_W),
    .ADDR_W (ADDR_W)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .osc_i     (osc_i),
    .ch_en_i   (ch_en_i),
    .start_i   (start_i),
    .mode_i    (mode_i),
    .stop_i    (stop_i),
    .win_len_i (win_len_i),
    .rd_addr_i (rd_addr_i),
    .rd_data_o (rd_data_o),
    .rd_ovf_o  (rd_ovf_o),
    .busy_o    (busy_o),
    .done_o    (done_o),
    .frame_o   (frame_o)
  );

  always #5 clk = ~clk;

  // Edge counter: after posedge number E, cyc == E.
  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int nCmp = 0;
  int nBad = 0;

  task automatic check(input string name, input int act, input int exp);
    nCmp++;
    if (act != exp) begin
      nBad++;
      $display("FAIL %s: actual=%0d required=%0d (edge %0d)", name, act, exp, cyc);
    end
  endtask

  // Scoreboard queues
  typedef struct { int edgeN; int frame; } doneExp_t;
  typedef struct { int addr; int data; int ovf; } rdExp_t;
  doneExp_t doneQ[$];
  rdExp_t   rdQ[$];
  logic     rdTag = 1'b0;

  // Oscillator model state
  int frameS[$];
  int runW = 1;
  int per [NUM_CH];
  int rises [MAX_FR][NUM_CH];
  int pick [6] = '{-1, 0, 1, 2, 3, 5};
  int frameExp = 0;

  // --------------------------------------------------------------------------
  // Oscillator driver: changes taps at most once per clk (on negedge) and only
  // in [start+3, start+W-4] of a frame, so every rise is seen and lands well
  // inside that frame's counting window.
  // --------------------------------------------------------------------------
  initial begin
    bit tog;
    forever begin
      @(negedge clk);
      for (int f = 0; f < frameS.size(); f++) begin
        if (f < MAX_FR && cyc >= frameS[f] + 3 && cyc <= frameS[f] + runW - 4) begin
          for (int c = 0; c < NUM_CH; c++) begin
            if (per[c] > 0)      tog = ((cyc % per[c]) == 0);
            else if (per[c] < 0) tog = ($urandom_range(0, 1) == 1);
            else                 tog = 1'b0;
            if (tog) begin
              osc_i[c] = ~osc_i[c];
              if (osc_i[c]) rises[f][c]++;
            end
          end
        end
      end
    end
  end

  // Done monitor
  initial begin
    doneExp_t d;
    forever begin
      @(posedge clk); #1;
      if (done_o) begin
        if (doneQ.size() == 0) begin
          check("unexpected_done", 1, 0);
        end else begin
          d = doneQ.pop_front();
          check("done_edge", cyc, d.edgeN);
          check("frame_o_at_done", int'(frame_o), d.frame);
        end
      end else if (doneQ.size() != 0 && cyc > doneQ[0].edgeN) begin
        d = doneQ.pop_front();
        check("done_missing", 0, 1);
      end
    end
  end

  // Read monitor: address is held across the posedge that registers it.
  initial begin
    rdExp_t r;
    forever begin
      @(posedge clk); #1;
      if (rdTag) begin
        if (rdQ.size() == 0) begin
          check("rd_queue_empty", 1, 0);
        end else begin
          r = rdQ.pop_front();
          check($sformatf("rd_data[%0d]", r.addr), int'(rd_data_o), r.data);
          check($sformatf("rd_ovf[%0d]", r.addr), int'(rd_ovf_o), r.ovf);
        end
      end
    end
  end

  // Reads every entry plus two out-of-range addresses.
  task automatic readBank(input int f, input logic [NUM_CH-1:0] en, input bit allZero);
    for (int a = 0; a < NUM_CH + 2; a++) begin
      rdExp_t e;
      int     addr;
      addr = (a < NUM_CH) ? a : ((a == NUM_CH) ? NUM_CH : (1 << ADDR_W) - 1);
      e.addr = addr;
      e.data = 0;
      e.ovf  = 0;
      if (!allZero && addr < NUM_CH && en[addr]) begin
        e.data = (rises[f][addr] > CNT_MAX) ? CNT_MAX : rises[f][addr];
        e.ovf  = (rises[f][addr] > CNT_MAX) ? 1 : 0;
      end
      @(negedge clk);
      rd_addr_i = ADDR_W'(addr);
      rdQ.push_back(e);
      rdTag = 1'b1;
    end
    @(negedge clk);
    rdTag = 1'b0;
  endtask

  task automatic startRun(input bit m, input logic [NUM_CH-1:0] en, input int w,
                          input bit waitEdge, output int s);
    if (waitEdge) @(negedge clk);
    start_i   = 1'b1;
    mode_i    = m;
    ch_en_i   = en;
    win_len_i = WIN_W'(w);
    s         = cyc + 1;
    runW      = (w == 0) ? 1 : w;
    frameS.delete();
    for (int f = 0; f < MAX_FR; f++)
      for (int c = 0; c < NUM_CH; c++) rises[f][c] = 0;
    @(negedge clk);
    // Scramble the configuration inputs to show they were latched.
    start_i   = 1'b0;
    mode_i    = ~m;
    ch_en_i   = ~en;
    win_len_i = WIN_W'($urandom);
  endtask

  task automatic pushDone(input int edgeN);
    doneExp_t d;
    frameExp++;
    d.edgeN = edgeN;
    d.frame = frameExp & 16'hFFFF;
    doneQ.push_back(d);
  endtask

  // Runs out a single-shot frame; a start and stop pulse mid-frame must be ignored.
  task automatic finishSingle(input int s, input logic [NUM_CH-1:0] en);
    int doneAt;
    doneAt = s + 3 + runW + NUM_CH;
    while (cyc < doneAt + 2) begin
      @(negedge clk);
      if (cyc == s + 5) begin
        start_i = 1'b1;
        stop_i  = 1'b1;
      end else begin
        start_i = 1'b0;
        stop_i  = 1'b0;
      end
    end
    check("busy_after_frame", int'(busy_o), 0);
    readBank(0, en, 1'b0);
  endtask

  task automatic runSingle(input logic [NUM_CH-1:0] en, input int w);
    int s;
    startRun(1'b0, en, w, 1'b1, s);
    frameS.push_back(s);
    pushDone(s + 3 + runW + NUM_CH);
    finishSingle(s, en);
  endtask

  task automatic runCont(input logic [NUM_CH-1:0] en, input int w);
    int s, fr, lastDone;
    startRun(1'b1, en, w, 1'b1, s);
    fr = 4 + runW + NUM_CH;
    for (int f = 0; f < 3; f++) begin
      frameS.push_back(s + f * fr);
      pushDone(s + f * fr + 3 + runW + NUM_CH);
    end
    lastDone = s + 2 * fr + 3 + runW + NUM_CH;
    // Wait long enough that a fourth frame would have completed and restarted.
    while (cyc < lastDone + fr + 2) begin
      @(negedge clk);
      stop_i = (cyc == s + 2 * fr + 5);
    end
    check("busy_after_stop", int'(busy_o), 0);
    check("frame_after_stop", int'(frame_o), frameExp);
    readBank(2, en, 1'b0);
  endtask

  task automatic checkAllZero(input string tag);
    check({tag, "_rd_data"}, int'(rd_data_o), 0);
    check({tag, "_rd_ovf"},  int'(rd_ovf_o), 0);
    check({tag, "_busy"},    int'(busy_o), 0);
    check({tag, "_done"},    int'(done_o), 0);
    check({tag, "_frame"},   int'(frame_o), 0);
  endtask

  // Watchdog
  initial begin
    #2000000;
    $display("FAIL watchdog: actual=timeout required=finish");
    $fatal(1, "watchdog expired");
  end

  // --------------------------------------------------------------------------
  // Main stimulus
  // --------------------------------------------------------------------------
  initial begin
    int s;
    logic [NUM_CH-1:0] en;
    int w;

    for (int c = 0; c < NUM_CH; c++) per[c] = 0;
    rst = 1'b1;
    repeat (3) @(negedge clk);
    checkAllZero("reset");
    rst = 1'b0;
    readBank(0, '0, 1'b1);

    // Single-shot, ch0 toggling every 4 clk, others static
    per = '{4, 0, 0, 0, 0};
    runSingle(5'b11111, 100);

    // Saturation and overflow on ch1
    per = '{0, 1, 0, 0, 0};
    runSingle(5'b11111, 300);

    // ch0 disabled, all toggling
    per = '{-1, -1, -1, -1, -1};
    runSingle(5'b11110, 120);

    // Random single-shot frames
    for (int it = 0; it < 4; it++) begin
      en = NUM_CH'($urandom);
      w  = $urandom_range(8, 150);
      for (int c = 0; c < NUM_CH; c++) per[c] = pick[$urandom_range(0, 5)];
      runSingle(en, w);
    end

    // Continuous mode, stop during the third frame
    per = '{-1, 2, -1, 0, 3};
    runCont(5'b10111, 20);

    // Zero window behaves as one cycle
    per = '{1, 1, 1, 1, 1};
    runSingle(5'b11111, 0);

    // Reset in the middle of COUNT
    per = '{-1, -1, -1, -1, -1};
    startRun(1'b0, 5'b11111, 80, 1'b1, s);
    frameS.push_back(s);
    pushDone(s + 3 + runW + NUM_CH);
    while (cyc < s + 30) @(negedge clk);
    rst = 1'b1;
    doneQ.delete();
    @(negedge clk);
    checkAllZero("midrst");
    rst      = 1'b0;
    frameExp = 0;
    startRun(1'b0, 5'b10101, 40, 1'b0, s);
    frameS.push_back(s);
    pushDone(s + 3 + runW + NUM_CH);
    readBank(0, '0, 1'b1);
    finishSingle(s, 5'b10101);

    repeat (3) @(negedge clk);
    check("done_queue_drained", doneQ.size(), 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", nCmp, nBad);
    $finish;
  end

endmodule
`default_nettype wire
